// File: rtl/manh_update_sequencer_if.sv
// Handshake/bus bundle between the training sequencer and the weight RAM + MAC datapath.
// WASTED_CYCLE_STALL exists only when WASTED_CYCLE_STALL_EN is defined.
interface manh_update_sequencer_if #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned EPOCH_W = 10
);
  logic               start;
  logic               mac_done;
  logic               training_done;
  logic [ADDR_W-1:0]  w_addr;
  logic               INITIAL_ROM_READ_FLAG;
  logic               old_weight_rd;
  logic               write_training;
  logic               layer_sel;
  logic               fwd_start;
  logic               first_manh_finished;
  logic               second_manh_finished;
  logic               training_mode;
  logic               stop;
  logic [EPOCH_W-1:0] epoch_cnt;
`ifdef WASTED_CYCLE_STALL_EN
  logic               WASTED_CYCLE_STALL;
`endif

  modport master (
    input  start, mac_done, training_done,
`ifdef WASTED_CYCLE_STALL_EN
    output WASTED_CYCLE_STALL,
`endif
    output w_addr, INITIAL_ROM_READ_FLAG, old_weight_rd, write_training, layer_sel,
           fwd_start, first_manh_finished, second_manh_finished, training_mode,
           stop, epoch_cnt
  );

  modport slave (
    output start, mac_done, training_done,
`ifdef WASTED_CYCLE_STALL_EN
    input  WASTED_CYCLE_STALL,
`endif
    input  w_addr, INITIAL_ROM_READ_FLAG, old_weight_rd, write_training, layer_sel,
           fwd_start, first_manh_finished, second_manh_finished, training_mode,
           stop, epoch_cnt
  );
endinterface

// File: rtl/manh_update_sequencer.sv
// Training-run sequencer: ROM weight load, then per epoch forward pass, Manhattan-rule
// updates of layer 1 and layer 2, convergence check. Optional macro: WASTED_CYCLE_STALL_EN.
module manh_update_sequencer #(
  parameter int unsigned N_W1      = 8,
  parameter int unsigned N_W2      = 4,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned MAX_EPOCH = 1000,
  parameter int unsigned EPOCH_W   = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  manh_update_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, ROM_LOAD, FWD, M1_RD, M1_WR, M2_RD, M2_WR, CHECK, DONE
`ifdef WASTED_CYCLE_STALL_EN
    , M1_STALL, M2_STALL
`endif
  } state_t;

  localparam logic [ADDR_W-1:0]  L1_LAST     = ADDR_W'(N_W1 - 1);
  localparam logic [ADDR_W-1:0]  L2_FIRST    = ADDR_W'(N_W1);
  localparam logic [ADDR_W-1:0]  W_LAST      = ADDR_W'(N_W1 + N_W2 - 1);
  localparam logic [EPOCH_W:0]   EPOCH_LIMIT = (EPOCH_W + 1)'(MAX_EPOCH);

  state_t           state;
  logic [EPOCH_W:0] epoch_nxt;

  // One extra bit so the limit compare stays correct when MAX_EPOCH == 2**EPOCH_W.
  assign epoch_nxt = {1'b0, bus.epoch_cnt} + (EPOCH_W + 1)'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                    <= IDLE;
      bus.w_addr               <= '0;
      bus.INITIAL_ROM_READ_FLAG <= 1'b0;
      bus.old_weight_rd        <= 1'b0;
      bus.write_training       <= 1'b0;
      bus.layer_sel            <= 1'b0;
      bus.fwd_start            <= 1'b0;
      bus.first_manh_finished  <= 1'b0;
      bus.second_manh_finished <= 1'b0;
      bus.training_mode        <= 1'b0;
      bus.stop                 <= 1'b0;
      bus.epoch_cnt            <= '0;
`ifdef WASTED_CYCLE_STALL_EN
      bus.WASTED_CYCLE_STALL   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state                     <= ROM_LOAD;
            bus.w_addr                <= '0;
            bus.epoch_cnt             <= '0;
            bus.stop                  <= 1'b0;
            bus.training_mode         <= 1'b1;
            bus.INITIAL_ROM_READ_FLAG <= 1'b1;
            bus.write_training        <= 1'b1;
          end
        end
        ROM_LOAD: begin
          if (bus.w_addr == W_LAST) begin
            state                     <= FWD;
            bus.INITIAL_ROM_READ_FLAG <= 1'b0;
            bus.write_training        <= 1'b0;
            bus.fwd_start             <= 1'b1;
          end else begin
            bus.w_addr <= bus.w_addr + ADDR_W'(1);
          end
        end
        FWD: begin
          // mac_done is not looked at during the fwd_start cycle.
          if (bus.fwd_start) begin
            bus.fwd_start <= 1'b0;
          end else if (bus.mac_done) begin
            state             <= M1_RD;
            bus.w_addr        <= '0;
            bus.old_weight_rd <= 1'b1;
            bus.layer_sel     <= 1'b0;
          end
        end
`ifdef WASTED_CYCLE_STALL_EN
        M1_RD: begin
          state                  <= M1_STALL;
          bus.old_weight_rd      <= 1'b0;
          bus.WASTED_CYCLE_STALL <= 1'b1;
        end
        M2_RD: begin
          state                  <= M2_STALL;
          bus.old_weight_rd      <= 1'b0;
          bus.WASTED_CYCLE_STALL <= 1'b1;
        end
        M1_STALL: begin
          state                   <= M1_WR;
          bus.WASTED_CYCLE_STALL  <= 1'b0;
          bus.write_training      <= 1'b1;
          bus.first_manh_finished <= (bus.w_addr == L1_LAST);
        end
        M2_STALL: begin
          state                    <= M2_WR;
          bus.WASTED_CYCLE_STALL   <= 1'b0;
          bus.write_training       <= 1'b1;
          bus.second_manh_finished <= (bus.w_addr == W_LAST);
        end
`else
        M1_RD: begin
          state                   <= M1_WR;
          bus.old_weight_rd       <= 1'b0;
          bus.write_training      <= 1'b1;
          bus.first_manh_finished <= (bus.w_addr == L1_LAST);
        end
        M2_RD: begin
          state                    <= M2_WR;
          bus.old_weight_rd        <= 1'b0;
          bus.write_training       <= 1'b1;
          bus.second_manh_finished <= (bus.w_addr == W_LAST);
        end
`endif
        M1_WR: begin
          bus.write_training      <= 1'b0;
          bus.first_manh_finished <= 1'b0;
          bus.old_weight_rd       <= 1'b1;
          if (bus.w_addr == L1_LAST) begin
            state         <= M2_RD;
            bus.w_addr    <= L2_FIRST;
            bus.layer_sel <= 1'b1;
          end else begin
            state      <= M1_RD;
            bus.w_addr <= bus.w_addr + ADDR_W'(1);
          end
        end
        M2_WR: begin
          bus.write_training       <= 1'b0;
          bus.second_manh_finished <= 1'b0;
          if (bus.w_addr == W_LAST) begin
            state         <= CHECK;
            bus.layer_sel <= 1'b0;
          end else begin
            state             <= M2_RD;
            bus.w_addr        <= bus.w_addr + ADDR_W'(1);
            bus.old_weight_rd <= 1'b1;
          end
        end
        CHECK: begin
          bus.epoch_cnt <= epoch_nxt[EPOCH_W-1:0];
          if (bus.training_done || epoch_nxt == EPOCH_LIMIT) begin
            state             <= DONE;
            bus.stop          <= 1'b1;
            bus.training_mode <= 1'b0;
          end else begin
            state         <= FWD;
            bus.fwd_start <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_manh_update_sequencer.sv
// Scoreboard bench for manh_update_sequencer: expected per-cycle output snapshots are
// queued as stimulus is applied and compared cycle by cycle as the DUT advances.
module tb_manh_update_sequencer;

  typedef struct packed {
    logic rom, rd, wr, lay, fwd, f1, f2, tm, stop, stall;
    logic [3:0] addr;
    logic [9:0] ep;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  v;
  } exp_t;

  localparam logic [9:0] ROM = 10'h200, RD = 10'h100, WR = 10'h080, LAY = 10'h040,
                         FWD = 10'h020, F1 = 10'h010, F2 = 10'h008, TM  = 10'h004,
                         STOP = 10'h002, STL = 10'h001;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1;
  logic start = 1'b0, mac_done = 1'b0, training_done = 1'b0;
  bit   sel = 1'b0;
  int   checks = 0, errors = 0;
  exp_t sb[$];
  obs_t obs_a, obs_b;

  always #5 clk = ~clk;

  manh_update_sequencer_if #(.ADDR_W(4), .EPOCH_W(10)) ifa ();
  manh_update_sequencer_if #(.ADDR_W(4), .EPOCH_W(10)) ifb ();

  assign ifa.start = start;  assign ifa.mac_done = mac_done;  assign ifa.training_done = training_done;
  assign ifb.start = start;  assign ifb.mac_done = mac_done;  assign ifb.training_done = training_done;

  manh_update_sequencer #(.N_W1(8), .N_W2(4), .ADDR_W(4), .MAX_EPOCH(1000), .EPOCH_W(10))
    dut_a (.clk(clk), .rst(rst_a), .bus(ifa.master));
  manh_update_sequencer #(.N_W1(8), .N_W2(4), .ADDR_W(4), .MAX_EPOCH(2), .EPOCH_W(10))
    dut_b (.clk(clk), .rst(rst_b), .bus(ifb.master));

  always_comb begin
    obs_a = '0;
    {obs_a.rom, obs_a.rd, obs_a.wr, obs_a.lay, obs_a.fwd} = {ifa.INITIAL_ROM_READ_FLAG,
      ifa.old_weight_rd, ifa.write_training, ifa.layer_sel, ifa.fwd_start};
    {obs_a.f1, obs_a.f2, obs_a.tm, obs_a.stop} = {ifa.first_manh_finished,
      ifa.second_manh_finished, ifa.training_mode, ifa.stop};
    obs_a.addr = ifa.w_addr;
    obs_a.ep   = ifa.epoch_cnt;
    obs_b = '0;
    {obs_b.rom, obs_b.rd, obs_b.wr, obs_b.lay, obs_b.fwd} = {ifb.INITIAL_ROM_READ_FLAG,
      ifb.old_weight_rd, ifb.write_training, ifb.layer_sel, ifb.fwd_start};
    {obs_b.f1, obs_b.f2, obs_b.tm, obs_b.stop} = {ifb.first_manh_finished,
      ifb.second_manh_finished, ifb.training_mode, ifb.stop};
    obs_b.addr = ifb.w_addr;
    obs_b.ep   = ifb.epoch_cnt;
`ifdef WASTED_CYCLE_STALL_EN
    obs_a.stall = ifa.WASTED_CYCLE_STALL;
    obs_b.stall = ifb.WASTED_CYCLE_STALL;
`endif
  end

  function automatic obs_t mk(input logic [9:0] f, input int a, input int ep);
    obs_t o;
    {o.rom, o.rd, o.wr, o.lay, o.fwd, o.f1, o.f2, o.tm, o.stop, o.stall} = f;
    o.addr = 4'(a);
    o.ep   = 10'(ep);
    return o;
  endfunction

  task automatic push(input string tag, input obs_t v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic check(input exp_t e);
    obs_t got;
    got = sel ? obs_b : obs_a;
    checks++;
    assert (got === e.v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, got, e.v);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n && sb.size() > 0; i++) begin
      @(posedge clk);
      #1;
      check(sb.pop_front());
    end
  endtask

  task automatic drain_all();
    while (sb.size() > 0) drain(1);
  endtask

  task automatic push_rom(input int ep);
    for (int a = 0; a < 12; a++) push($sformatf("rom_a%0d", a), mk(ROM | WR | TM, a, ep));
  endtask

  task automatic push_w(input bit lay, input int a, input int ep);
    logic [9:0] l, fin;
    l   = lay ? LAY : 10'h000;
    fin = (!lay && a == 7) ? F1 : (lay && a == 11) ? F2 : 10'h000;
    push($sformatf("e%0d_rd_a%0d", ep, a), mk(RD | TM | l, a, ep));
`ifdef WASTED_CYCLE_STALL_EN
    push($sformatf("e%0d_stall_a%0d", ep, a), mk(STL | TM | l, a, ep));
`endif
    push($sformatf("e%0d_wr_a%0d", ep, a), mk(WR | TM | l | fin, a, ep));
  endtask

  task automatic push_fwd(input int len, input int ep);
    push($sformatf("e%0d_fwd0", ep), mk(FWD | TM, 11, ep));
    for (int i = 1; i < len; i++) push($sformatf("e%0d_fwd%0d", ep, i), mk(TM, 11, ep));
  endtask

  // One epoch starting from the cycle before FWD entry; len = FWD cycles.
  task automatic epoch(input int ep, input int len, input bit early, input bit noise,
                       input bit td_end, input bit ends);
    if (early) mac_done = 1'b1;
    training_done = noise;
    start         = noise;
    push_fwd(len, ep);
    drain_all();
    mac_done = 1'b1;
    for (int a = 0; a < 8; a++) push_w(1'b0, a, ep);
    drain(1);
    mac_done = 1'b0;
    start    = 1'b0;
    drain_all();
    for (int a = 8; a < 12; a++) push_w(1'b1, a, ep);
    drain_all();
    training_done = td_end;
    push($sformatf("e%0d_check", ep), mk(TM, 11, ep));
    drain_all();
    if (ends) begin
      push($sformatf("e%0d_done", ep), mk(STOP, 11, ep + 1));
      drain_all();
      training_done = 1'b0;
    end
  endtask

  initial begin
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    push("reset_a", mk(10'h000, 0, 0));
    drain_all();
    rst_a = 1'b1;
    for (int i = 0; i < 2; i++) push("idle_a", mk(10'h000, 0, 0));
    drain_all();

    // Run into layer-1 update, then reset asynchronously in the addr-3 write cycle.
    start = 1'b1;
    push_rom(0);
    drain(1);
    start = 1'b0;
    drain_all();
    push_fwd(2, 0);
    drain_all();
    mac_done = 1'b1;
    for (int a = 0; a < 4; a++) push_w(1'b0, a, 0);
    drain(1);
    mac_done = 1'b0;
    drain_all();
    rst_a = 1'b0;
    #1;
    push("async_rst", mk(10'h000, 0, 0));
    check(sb.pop_front());
    push("rst_edge", mk(10'h000, 0, 0));
    drain_all();
    rst_a = 1'b1;
    for (int i = 0; i < 3; i++) push("idle_no_start", mk(10'h000, 0, 0));
    drain_all();

    // Full run; stray start pulses and training_done outside CHECK are ignored.
    start = 1'b1;
    push_rom(0);
    drain(1);
    start = 1'b0;
    drain(4);
    start = 1'b1;
    drain(1);
    start = 1'b0;
    drain_all();
    epoch(0, 6, 1'b0, 1'b1, 1'b0, 1'b0);
    epoch(1, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    epoch(2, 3, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) push("done_hold", mk(STOP, 11, 3));
    drain_all();

    // Epoch limit of 2 on the second instance, then a restart from DONE.
    rst_a = 1'b0;
    sel   = 1'b1;
    push("reset_b", mk(10'h000, 0, 0));
    drain_all();
    rst_b = 1'b1;
    start = 1'b1;
    push_rom(0);
    drain(1);
    start = 1'b0;
    drain_all();
    epoch(0, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    epoch(1, 4, 1'b0, 1'b0, 1'b0, 1'b1);
    push("b_done_hold", mk(STOP, 11, 2));
    drain_all();
    start = 1'b1;
    push_rom(0);
    drain(1);
    start = 1'b0;
    drain_all();
    push("b_restart_fwd", mk(FWD | TM, 11, 0));
    drain_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
